// File: rtl/ext_irq_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// ext_irq_ctrl_pkg
// Shared constants for the platform-level external interrupt controller:
//   - register byte offsets on the data-memory register port
//   - gateway state encodings used by irq_gateway
//   - source ID width and the largest supported source count
// No ports; imported by ext_irq_ctrl and irq_gateway.
// ---------------------------------------------------------------------------
package ext_irq_ctrl_pkg;

    // Largest source count the register map can describe (IDs fit in 4 bits).
    localparam int MAX_SRC  = 16;
    localparam int SRC_ID_W = 4;

    typedef logic [SRC_ID_W-1:0] src_id_t;

    // Register byte offsets.
    localparam logic [7:0] PLIC_PRIO_BASE = 8'h00;
    localparam logic [7:0] PLIC_ENABLE    = 8'h40;
    localparam logic [7:0] PLIC_THRESH    = 8'h44;
    localparam logic [7:0] PLIC_CLAIM     = 8'h48;
    localparam logic [7:0] PLIC_PENDING   = 8'h4C;

    // Gateway state encodings.
    localparam logic [1:0] GW_IDLE    = 2'd0;
    localparam logic [1:0] GW_PEND    = 2'd1;
    localparam logic [1:0] GW_CLAIMED = 2'd2;

endpackage

// File: rtl/irq_gateway.sv
// ---------------------------------------------------------------------------
// irq_gateway
// Per-source interrupt gateway. Turns a level-sensitive line into a single
// outstanding request that stays pending until claimed, and refuses new
// requests until software completes the claimed one.
// Ports:
//   clk          system clock
//   reset        asynchronous active-low reset
//   irq          level interrupt line for this source
//   claim_hit    a claim read returned this source's ID this cycle
//   complete_hit a complete write named this source's ID this cycle
//   pending      high while the gateway holds an unclaimed request
// ---------------------------------------------------------------------------
module irq_gateway
    import ext_irq_ctrl_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic irq,
    input  logic claim_hit,
    input  logic complete_hit,
    output logic pending
);

    logic [1:0] state;

    // A complete returns the gateway to IDLE first; a line that is still
    // high is only sampled again from IDLE, so it re-pends one cycle later.
    // Dropping irq while PENDING has no effect: the request is latched.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= GW_IDLE;
        end else begin
            case (state)
                GW_IDLE:    if (irq)          state <= GW_PEND;
                GW_PEND:    if (claim_hit)    state <= GW_CLAIMED;
                GW_CLAIMED: if (complete_hit) state <= GW_IDLE;
                default:                      state <= GW_IDLE;
            endcase
        end
    end

    assign pending = (state == GW_PEND);

endmodule

// File: rtl/ext_irq_ctrl.sv
// ---------------------------------------------------------------------------
// ext_irq_ctrl
// Platform-level external interrupt controller. Collects NUM_SRC-1 level
// interrupt lines (ID 0 is reserved for "no interrupt"), arbitrates among
// pending+enabled sources by priority, and drives MEIP to the CSR file.
// Software configures priority/enable/threshold and claims/completes
// interrupts through a word-addressed register port.
// Ports:
//   clk        system clock
//   reset      asynchronous active-low reset
//   irq_src    level interrupt lines (bit 0 ignored)
//   reg_wr     register write strobe
//   reg_rd     register read strobe
//   reg_addr   byte address (word aligned)
//   reg_wdata  write data
//   reg_rdata  registered read data, holds until the next read
//   meip       registered external interrupt pending
// ---------------------------------------------------------------------------
module ext_irq_ctrl
    import ext_irq_ctrl_pkg::*;
#(
    parameter int NUM_SRC = 8,
    parameter int PRIO_W  = 3
)
(
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_SRC-1:0] irq_src,
    input  logic               reg_wr,
    input  logic               reg_rd,
    input  logic [7:0]         reg_addr,
    input  logic [31:0]        reg_wdata,
    output logic [31:0]        reg_rdata,
    output logic               meip
);

    // Priority storage is sized for the maximum source count so the 4-bit
    // register index can address it directly; entries at or above NUM_SRC
    // and entry 0 are never written and stay zero.
    logic [PRIO_W-1:0]  prio [MAX_SRC];
    logic [NUM_SRC-1:0] enable;
    logic [PRIO_W-1:0]  threshold;
    logic [NUM_SRC-1:0] pending;

    src_id_t            best_id;
    logic [PRIO_W-1:0]  best_prio;

    logic [7:0]         prio_off;
    logic               prio_sel;
    src_id_t            prio_idx;
    logic               claim_fire;
    logic               complete_fire;
    src_id_t            complete_id;
    logic [31:0]        rd_val;
    logic               unused_bits;

    assign prio_off = reg_addr - PLIC_PRIO_BASE;
    assign prio_sel = (prio_off[1:0] == 2'b00) && (prio_off[7:2] < 6'(NUM_SRC));
    assign prio_idx = prio_off[5:2];

    // A read that collides with a write is suppressed, so it must not claim.
    assign claim_fire    = reg_rd && !reg_wr && (reg_addr == PLIC_CLAIM);
    assign complete_fire = reg_wr && (reg_addr == PLIC_CLAIM);
    assign complete_id   = reg_wdata[SRC_ID_W-1:0];

    assign unused_bits = ^{reg_wdata[31:NUM_SRC], irq_src[0]};

    // Arbitration: strict '>' while scanning upward keeps the lowest ID on
    // a priority tie; priority 0 can never beat the initial best_prio of 0.
    always_comb begin
        best_id   = '0;
        best_prio = '0;
        for (int i = 1; i < NUM_SRC; i++) begin
            if (pending[i] && enable[i] && (prio[i] > best_prio)) begin
                best_prio = prio[i];
                best_id   = src_id_t'(i);
            end
        end
    end

    // Configuration registers. Source 0 priority and enable bit 0 are
    // hard-wired to zero.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < MAX_SRC; i++) begin
                prio[i] <= '0;
            end
            enable    <= '0;
            threshold <= '0;
        end else if (reg_wr) begin
            if (prio_sel && (prio_idx != '0)) begin
                prio[prio_idx] <= reg_wdata[PRIO_W-1:0];
            end
            if (reg_addr == PLIC_ENABLE) begin
                enable <= {reg_wdata[NUM_SRC-1:1], 1'b0};
            end
            if (reg_addr == PLIC_THRESH) begin
                threshold <= reg_wdata[PRIO_W-1:0];
            end
        end
    end

    // Read mux; unmapped addresses read zero.
    always_comb begin
        rd_val = '0;
        if (prio_sel) begin
            rd_val = 32'(prio[prio_idx]);
        end else begin
            case (reg_addr)
                PLIC_ENABLE:  rd_val = 32'(enable);
                PLIC_THRESH:  rd_val = 32'(threshold);
                PLIC_CLAIM:   rd_val = 32'(best_id);
                PLIC_PENDING: rd_val = 32'(pending);
                default:      rd_val = '0;
            endcase
        end
    end

    // Registered outputs: read data holds between reads, meip follows the
    // arbitration result with one cycle of latency.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            reg_rdata <= '0;
            meip      <= 1'b0;
        end else begin
            meip <= (best_prio > threshold);
            if (reg_rd) begin
                reg_rdata <= reg_wr ? 32'd0 : rd_val;
            end
        end
    end

    assign pending[0] = 1'b0;

    for (genvar i = 1; i < NUM_SRC; i++) begin : g_gw
        irq_gateway u_gw (
            .clk          (clk),
            .reset        (reset),
            .irq          (irq_src[i]),
            .claim_hit    (claim_fire && (best_id == src_id_t'(i))),
            .complete_hit (complete_fire && (complete_id == src_id_t'(i))),
            .pending      (pending[i])
        );
    end

endmodule

// File: tb/tb_ext_irq_ctrl.sv
// ---------------------------------------------------------------------------
// tb_ext_irq_ctrl
// Self-checking bench for ext_irq_ctrl: directed scenarios followed by
// randomized register traffic, checked by a scoreboard against a
// behavioural model of the controller.
// ---------------------------------------------------------------------------
module tb_ext_irq_ctrl;

    localparam int NS = 8;
    localparam int PW = 3;

    logic          clk;
    logic          reset;
    logic [NS-1:0] irq_src;
    logic          reg_wr;
    logic          reg_rd;
    logic [7:0]    reg_addr;
    logic [31:0]   reg_wdata;
    logic [31:0]   reg_rdata;
    logic          meip;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic        rd;
        logic [31:0] rdata;
        logic        meip;
    } exp_t;

    exp_t sb_q[$];

    // Behavioural model: configuration plus two sets of source IDs, those
    // holding an unclaimed request and those claimed but not yet completed.
    int unsigned   m_prio [NS];
    logic [NS-1:0] m_en;
    int unsigned   m_thr;
    logic [NS-1:0] m_pend;
    logic [NS-1:0] m_clm;
    logic [NS-1:0] irq_lvl;

    ext_irq_ctrl #(.NUM_SRC(NS), .PRIO_W(PW)) dut (
        .clk       (clk),
        .reset     (reset),
        .irq_src   (irq_src),
        .reg_wr    (reg_wr),
        .reg_rd    (reg_rd),
        .reg_addr  (reg_addr),
        .reg_wdata (reg_wdata),
        .reg_rdata (reg_rdata),
        .meip      (meip)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_output(input string name, input logic [31:0] act,
                                input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t",
                     name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NS; i++) m_prio[i] = 0;
        m_en   = '0;
        m_thr  = 0;
        m_pend = '0;
        m_clm  = '0;
    endtask

    // Drives one clock cycle of stimulus, predicts the DUT response from the
    // model's view of the cycle, queues the prediction, and advances the
    // model. Returns 2 time units after the sampling edge.
    task automatic apply_stimulus(input logic wr, input logic rd,
                                  input logic [7:0] addr, input logic [31:0] wdata);
        int unsigned win;
        int unsigned best;
        int unsigned cmp_id;
        int unsigned idx;
        logic        claim_ok;
        logic        cmp_ok;
        exp_t        e;

        irq_src   = irq_lvl;
        reg_wr    = wr;
        reg_rd    = rd;
        reg_addr  = addr;
        reg_wdata = wdata;

        win  = 0;
        best = 0;
        for (int i = 1; i < NS; i++) begin
            if (m_pend[i] && m_en[i] && m_prio[i] > best) begin
                best = m_prio[i];
                win  = i;
            end
        end

        idx = int'(addr) / 4;
        e.rd    = rd;
        e.meip  = (best > m_thr);
        e.rdata = 0;
        if (rd && !wr) begin
            if (addr % 4 == 0 && idx < NS)  e.rdata = m_prio[idx];
            else if (addr == 8'h40)         e.rdata = 32'(m_en);
            else if (addr == 8'h44)         e.rdata = m_thr;
            else if (addr == 8'h48)         e.rdata = win;
            else if (addr == 8'h4C)         e.rdata = 32'(m_pend);
        end
        sb_q.push_back(e);

        claim_ok = rd && !wr && addr == 8'h48 && win != 0;
        cmp_ok   = wr && addr == 8'h48;
        cmp_id   = int'(wdata[3:0]);

        // Each source is either waiting to be claimed, claimed, or free; only
        // a source that was free at the start of the cycle takes a new request.
        for (int i = 1; i < NS; i++) begin
            if (m_pend[i]) begin
                if (claim_ok && win == i) begin
                    m_pend[i] = 1'b0;
                    m_clm[i]  = 1'b1;
                end
            end else if (m_clm[i]) begin
                if (cmp_ok && cmp_id == i) m_clm[i] = 1'b0;
            end else if (irq_lvl[i]) begin
                m_pend[i] = 1'b1;
            end
        end

        if (wr) begin
            if (addr % 4 == 0 && idx < NS && idx != 0) m_prio[idx] = wdata % (1 << PW);
            if (addr == 8'h40) m_en  = wdata[NS-1:0] & ~NS'(1);
            if (addr == 8'h44) m_thr = wdata % (1 << PW);
        end

        @(posedge clk);
        #2;
    endtask

    task automatic wr_reg(input logic [7:0] a, input logic [31:0] d);
        apply_stimulus(1'b1, 1'b0, a, d);
    endtask

    task automatic rd_reg(input logic [7:0] a);
        apply_stimulus(1'b0, 1'b1, a, 32'd0);
    endtask

    task automatic idle();
        apply_stimulus(1'b0, 1'b0, 8'h00, 32'd0);
    endtask

    // Scoreboard monitor: one prediction per driven cycle, compared just
    // after the edge that produces it.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                check_output("sb_meip", {31'd0, meip}, {31'd0, e.meip});
                if (e.rd) check_output("sb_rdata", reg_rdata, e.rdata);
            end
        end
    end

    initial begin
        int unsigned op;
        int unsigned sel;
        logic [7:0]  ra;
        logic [7:0]  addr_tab [6];

        addr_tab[0] = 8'h40; addr_tab[1] = 8'h44; addr_tab[2] = 8'h48;
        addr_tab[3] = 8'h4C; addr_tab[4] = 8'h50; addr_tab[5] = 8'h41;

        reset     = 1'b0;
        irq_lvl   = '0;
        irq_src   = '0;
        reg_wr    = 1'b0;
        reg_rd    = 1'b0;
        reg_addr  = '0;
        reg_wdata = '0;
        model_reset();
        repeat (3) @(posedge clk);
        #2;
        check_output("reset_meip", {31'd0, meip}, 32'd0);
        check_output("reset_rdata", reg_rdata, 32'd0);
        reset = 1'b1;
        idle();

        // Single source, one-cycle pulse.
        wr_reg(8'h08, 32'd1);
        wr_reg(8'h40, 32'h04);
        wr_reg(8'h44, 32'd0);
        irq_lvl = 8'h04; idle(); irq_lvl = 8'h00;
        rd_reg(8'h4C);
        check_output("single_pending", reg_rdata, 32'h04);
        check_output("single_meip_on", {31'd0, meip}, 32'd1);
        rd_reg(8'h48);
        check_output("single_claim", reg_rdata, 32'd2);
        idle();
        check_output("single_meip_off", {31'd0, meip}, 32'd0);
        wr_reg(8'h48, 32'd2);
        rd_reg(8'h4C);
        check_output("single_pend_after", reg_rdata, 32'h00);

        // Priority ordering with a tie between 5 and 6.
        wr_reg(8'h04, 32'd2);
        wr_reg(8'h14, 32'd5);
        wr_reg(8'h18, 32'd5);
        wr_reg(8'h40, 32'h62);
        irq_lvl = 8'h62; idle(); irq_lvl = 8'h00;
        idle();
        rd_reg(8'h48); check_output("tie_claim_a", reg_rdata, 32'd5);
        rd_reg(8'h48); check_output("tie_claim_b", reg_rdata, 32'd6);
        rd_reg(8'h48); check_output("tie_claim_c", reg_rdata, 32'd1);
        rd_reg(8'h48); check_output("tie_claim_none", reg_rdata, 32'd0);
        wr_reg(8'h48, 32'd5);
        wr_reg(8'h48, 32'd6);
        wr_reg(8'h48, 32'd1);

        // Threshold comparison is strict.
        wr_reg(8'h10, 32'd3);
        wr_reg(8'h40, 32'h10);
        wr_reg(8'h44, 32'd3);
        irq_lvl = 8'h10; idle(); irq_lvl = 8'h00;
        idle(); idle();
        check_output("thr_equal", {31'd0, meip}, 32'd0);
        wr_reg(8'h44, 32'd2);
        idle();
        check_output("thr_below", {31'd0, meip}, 32'd1);
        wr_reg(8'h40, 32'h00);
        idle();
        check_output("thr_disabled", {31'd0, meip}, 32'd0);
        wr_reg(8'h40, 32'h10);
        wr_reg(8'h44, 32'd0);
        rd_reg(8'h48); check_output("thr_claim", reg_rdata, 32'd4);
        wr_reg(8'h48, 32'd4);

        // Level line held high re-pends after complete.
        wr_reg(8'h1C, 32'd1);
        wr_reg(8'h40, 32'h80);
        irq_lvl = 8'h80; idle();
        rd_reg(8'h48); check_output("level_claim", reg_rdata, 32'd7);
        wr_reg(8'h48, 32'd7);
        rd_reg(8'h4C); check_output("level_idle", reg_rdata, 32'h00);
        rd_reg(8'h4C); check_output("level_repend", reg_rdata, 32'h80);
        irq_lvl = 8'h00;
        rd_reg(8'h48);
        wr_reg(8'h48, 32'd7);

        // Illegal operations.
        wr_reg(8'h0C, 32'd2);
        wr_reg(8'h40, 32'h08);
        irq_lvl = 8'h08; idle(); irq_lvl = 8'h00;
        wr_reg(8'h48, 32'd3);
        rd_reg(8'h4C); check_output("illegal_cmp", reg_rdata, 32'h08);
        apply_stimulus(1'b1, 1'b1, 8'h48, 32'd0);
        check_output("rdwr_rdata", reg_rdata, 32'd0);
        rd_reg(8'h4C); check_output("rdwr_noclaim", reg_rdata, 32'h08);
        rd_reg(8'h48); check_output("illegal_claim3", reg_rdata, 32'd3);
        wr_reg(8'h48, 32'd0);
        rd_reg(8'h48); check_output("empty_claim", reg_rdata, 32'd0);

        // Mid-operation reset with source 3 claimed and meip raised.
        wr_reg(8'h04, 32'd2);
        wr_reg(8'h40, 32'h0A);
        irq_lvl = 8'h02; idle(); irq_lvl = 8'h00;
        rd_reg(8'h40);
        check_output("pre_reset_meip", {31'd0, meip}, 32'd1);
        reset = 1'b0;
        #1;
        check_output("async_meip", {31'd0, meip}, 32'd0);
        check_output("async_rdata", reg_rdata, 32'd0);
        model_reset();
        sb_q.delete();
        @(posedge clk);
        #2;
        reset = 1'b1;
        rd_reg(8'h4C); check_output("post_reset_pend", reg_rdata, 32'h00);

        // Randomized traffic.
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 3) == 0) irq_lvl = NS'($urandom) & NS'($urandom) & ~NS'(1);
            op = $urandom_range(0, 9);
            sel = $urandom_range(0, 15);
            ra = (sel < 10) ? 8'(sel * 4) : addr_tab[sel - 10];
            case (op)
                0:       wr_reg(8'($urandom_range(0, 9) * 4), $urandom);
                1:       wr_reg(8'h40, $urandom);
                2:       wr_reg(8'h44, $urandom);
                3, 4:    wr_reg(8'h48, 32'($urandom_range(0, 9)));
                5, 6:    rd_reg(8'h48);
                7:       rd_reg(ra);
                8:       apply_stimulus(1'b1, 1'b1, ra, $urandom);
                default: idle();
            endcase
        end
        idle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
